paddle_ctrl: RTL and testbench
==============================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter NUM_PADDLES, default 2: number of independent paddle channels.
REQ-002 Parameter POS_W, default 10: width of each position output.
REQ-003 Parameter POS_MIN, default 0; POS_MAX, default 416: inclusive clamp range of position.
REQ-004 Parameter POS_INIT, default 208: position after reset.
REQ-005 Parameter STEP, default 4: pixels moved per accepted count or per held-button frame.
REQ-006 Parameter DEB_CYCLES, default 15: cycles an input must stay stable before acceptance, range 1..255.
REQ-007 Parameter ACC_W, default 6: width of the signed per-channel delta accumulator.
REQ-008 Parameter VSYNC_ACTIVE_LOW, default 1: vsync polarity.
REQ-009 clk  in  1  single clock; all state updates on its rising edge.
REQ-010 rst_n  in  1  reset, synchronous, active-low.
REQ-011 in_a  in  NUM_PADDLES  channel A (quadrature phase A, or up button), asynchronous.
REQ-012 in_b  in  NUM_PADDLES  channel B (quadrature phase B, or down button), asynchronous.
REQ-013 mode  in  NUM_PADDLES  per channel: 0 = quadrature, 1 = button.
REQ-014 vsync  in  1  frame sync from the sync generator.
REQ-015 pos  out  NUM_PADDLES*POS_W  packed positions, channel i at bits [i*POS_W +: POS_W].
REQ-016 moved  out  NUM_PADDLES  one-cycle pulse when the channel's pos changed.
REQ-017 qerr  out  NUM_PADDLES  one-cycle pulse on an illegal quadrature transition.

Function
REQ-018 Each in_a/in_b bit SHALL pass a 2-flop synchroniser before any other use.
REQ-019 Debounce: a synchronised bit SHALL update its debounced value only after differing from it for DEB_CYCLES consecutive cycles; any return to the old value resets the count.
REQ-020 Frame strobe: asserts one cycle after the synchronised vsync enters its active level (edge-detected), once per frame.
REQ-021 Quadrature mode, debounced (A,B) sequence 00->01->11->10->00: +1 to the accumulator per step; reverse order: -1; no change: 0.
REQ-022 Quadrature mode, simultaneous change of both bits (00<->11, 01<->10): accumulator unchanged, qerr pulses one cycle.
REQ-023 Accumulator SHALL saturate at -2^(ACC_W-1) and 2^(ACC_W-1)-1; no wrap.
REQ-024 Button mode: on each frame strobe, delta = +1 if only B is held, -1 if only A is held, 0 if both or neither; the accumulator is unused and held at 0.
REQ-025 On a frame strobe: pos_next = clamp(pos + delta*STEP, POS_MIN, POS_MAX), computed at signed POS_W+ACC_W+3 bits; pos updates one cycle after the strobe.
REQ-026 The accumulator SHALL clear on the frame strobe; a count arriving in the strobe cycle SHALL be the new accumulator value (not lost).
REQ-027 pos SHALL change only on frame-strobe updates.
REQ-028 moved pulses in the same cycle pos takes a different value; no pulse if the clamp leaves pos unchanged.
REQ-029 A mode change takes effect on the next cycle; the accumulator clears that cycle.
REQ-030 Channels SHALL be fully independent; no interaction across channels.

Reset
REQ-031 While rst_n=0 at a clock edge: all pos = POS_INIT, accumulators 0, debounce counters 0, synchroniser, debounced and vsync edge registers 0 (vsync register = inactive level), moved and qerr 0.
REQ-032 Reset SHALL abort any pending frame update; the first strobe after reset uses only counts accumulated after release.
REQ-033 A first debounced transition 00->11 after reset SHALL be flagged qerr and ignored.

Structure
REQ-034 Shared package pong_pkg holds the default constants (screen height 480, paddle height 64, POS_INIT, STEP) and the mode encoding enum.
REQ-035 One sub-module paddle_chan (sync, debounce, quadrature decode, accumulator, clamp) instantiated NUM_PADDLES times by generate; the frame-strobe edge detector lives in paddle_ctrl.

Verification
REQ-036 Reset release, no input activity, 3 frames -> pos = 208 on both channels, moved never pulses.
REQ-037 Channel 0 quadrature: 5 forward Gray steps (each held 20 cycles) in one frame -> after strobe pos0 = 228, moved0 one pulse, pos1 = 208.
REQ-038 Channel 1 button mode, in_a held for 60 frames -> pos1 steps -4 per frame, clamps at 0, moved1 stops pulsing at 0.
REQ-039 Chatter: in_a toggles every 5 cycles for 200 cycles with DEB_CYCLES=15 -> no count, pos unchanged, qerr 0.
REQ-040 Illegal 00->11 debounced transition -> qerr pulse of 1 cycle, accumulator unchanged, pos unchanged at next strobe.
REQ-041 40 forward steps in one frame with ACC_W=6 -> accumulator saturates at 31, pos = min(208+124, 416) = 332; rst_n low mid-frame -> pos returns to 208.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants and encodings for the pong paddle front end.
// Defaults describe a 480-line screen with a 64-line paddle.
package pong_pkg;

  localparam int SCREEN_H       = 480;
  localparam int PADDLE_H       = 64;
  localparam int POS_MIN_DEF    = 0;
  localparam int POS_MAX_DEF    = SCREEN_H - PADDLE_H;
  localparam int POS_INIT_DEF   = 208;
  localparam int STEP_DEF       = 4;
  localparam int DEB_CYCLES_DEF = 15;
  localparam int ACC_W_DEF      = 6;

  typedef enum logic {
    MODE_QUAD   = 1'b0,
    MODE_BUTTON = 1'b1
  } pad_mode_e;

  // Position of an {A,B} pair in the Gray cycle 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

endpackage

// File: rtl/paddle_chan.sv
// One paddle channel: input synchronisers, debounce, quadrature decode,
// saturating delta accumulator and clamped position update on frame strobe.
module paddle_chan
  import pong_pkg::*;
#(
  parameter int POS_W      = 10,
  parameter int POS_MIN    = POS_MIN_DEF,
  parameter int POS_MAX    = POS_MAX_DEF,
  parameter int POS_INIT   = POS_INIT_DEF,
  parameter int STEP       = STEP_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int ACC_W      = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             mode_i,
  input  logic             strobe_i,
  output logic [POS_W-1:0] pos_o,
  output logic             moved_o,
  output logic             qerr_o
);

  localparam int SW = POS_W + ACC_W + 3;
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_NEG = '1;
  localparam logic signed [SW-1:0]    STEP_S  = SW'(STEP);
  localparam logic signed [SW-1:0]    MIN_S   = SW'(POS_MIN);
  localparam logic signed [SW-1:0]    MAX_S   = SW'(POS_MAX);

  // Bit 1 carries A, bit 0 carries B throughout.
  logic [1:0]             sync1_q, sync2_q;
  logic [1:0]             deb_q, deb_d;
  logic [7:0]             cnt_q [2];
  logic [7:0]             cnt_d [2];
  logic                   mode_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [POS_W-1:0]       pos_q, pos_new;
  logic                   moved_q, qerr_q;

  logic                   is_quad, mode_chg, fwd, bwd, both;
  logic signed [ACC_W-1:0] qstep, acc_inc, delta;
  logic signed [SW-1:0]   pos_ext, delta_ext, sum;

  // A bit is accepted once it has disagreed with the debounced value for
  // DEB_CYCLES consecutive cycles; agreeing again restarts the count.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    is_quad  = (pad_mode_e'(mode_q) == MODE_QUAD);
    mode_chg = (mode_i != mode_q);
    fwd      = (gray_idx(deb_d) == gray_idx(deb_q) + 2'd1);
    bwd      = (gray_idx(deb_q) == gray_idx(deb_d) + 2'd1);
    both     = (deb_d == ~deb_q);
    qstep    = fwd ? ACC_ONE : (bwd ? ACC_NEG : '0);

    acc_inc = acc_q;
    if (fwd && acc_q != ACC_MAX) acc_inc = acc_q + ACC_ONE;
    if (bwd && acc_q != ACC_MIN) acc_inc = acc_q - ACC_ONE;

    // On the strobe the current accumulator is consumed and this cycle's
    // count becomes the start of the next frame.
    if (mode_chg || !is_quad) begin
      acc_d = '0;
    end else if (strobe_i) begin
      acc_d = qstep;
    end else begin
      acc_d = acc_inc;
    end

    if (is_quad) begin
      delta = acc_q;
    end else if (deb_q[0] && !deb_q[1]) begin
      delta = ACC_ONE;
    end else if (deb_q[1] && !deb_q[0]) begin
      delta = ACC_NEG;
    end else begin
      delta = '0;
    end
  end

  always_comb begin
    pos_ext   = {{(ACC_W+3){1'b0}}, pos_q};
    delta_ext = {{(POS_W+3){delta[ACC_W-1]}}, delta};
    sum       = pos_ext + delta_ext * STEP_S;
    if (sum < MIN_S) begin
      pos_new = POS_W'(POS_MIN);
    end else if (sum > MAX_S) begin
      pos_new = POS_W'(POS_MAX);
    end else begin
      pos_new = sum[POS_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      mode_q   <= 1'b0;
      acc_q    <= '0;
      pos_q    <= POS_W'(POS_INIT);
      moved_q  <= 1'b0;
      qerr_q   <= 1'b0;
    end else begin
      sync1_q  <= {a_i, b_i};
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      mode_q   <= mode_i;
      acc_q    <= acc_d;
      qerr_q   <= is_quad && both;
      if (strobe_i) begin
        pos_q   <= pos_new;
        moved_q <= (pos_new != pos_q);
      end else begin
        moved_q <= 1'b0;
      end
    end
  end

  assign pos_o   = pos_q;
  assign moved_o = moved_q;
  assign qerr_o  = qerr_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle controller top: vsync synchroniser and frame-strobe edge detector
// shared by NUM_PADDLES independent paddle channels.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int NUM_PADDLES      = 2,
  parameter int POS_W            = 10,
  parameter int POS_MIN          = POS_MIN_DEF,
  parameter int POS_MAX          = POS_MAX_DEF,
  parameter int POS_INIT         = POS_INIT_DEF,
  parameter int STEP             = STEP_DEF,
  parameter int DEB_CYCLES       = DEB_CYCLES_DEF,
  parameter int ACC_W            = ACC_W_DEF,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PADDLES-1:0]       in_a,
  input  logic [NUM_PADDLES-1:0]       in_b,
  input  logic [NUM_PADDLES-1:0]       mode,
  input  logic                         vsync,
  output logic [NUM_PADDLES*POS_W-1:0] pos,
  output logic [NUM_PADDLES-1:0]       moved,
  output logic [NUM_PADDLES-1:0]       qerr
);

  localparam logic INACT = (VSYNC_ACTIVE_LOW != 0);

  logic vs_s1_q, vs_s2_q, vs_prev_q, strobe_q;

  // Strobe fires once per frame, the cycle after synchronised vsync first
  // reads active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_s1_q   <= INACT;
      vs_s2_q   <= INACT;
      vs_prev_q <= INACT;
      strobe_q  <= 1'b0;
    end else begin
      vs_s1_q   <= vsync;
      vs_s2_q   <= vs_s1_q;
      vs_prev_q <= vs_s2_q;
      strobe_q  <= (vs_s2_q != INACT) && (vs_prev_q == INACT);
    end
  end

  for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_chan
    paddle_chan #(
      .POS_W     (POS_W),
      .POS_MIN   (POS_MIN),
      .POS_MAX   (POS_MAX),
      .POS_INIT  (POS_INIT),
      .STEP      (STEP),
      .DEB_CYCLES(DEB_CYCLES),
      .ACC_W     (ACC_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .a_i     (in_a[g]),
      .b_i     (in_b[g]),
      .mode_i  (mode[g]),
      .strobe_i(strobe_q),
      .pos_o   (pos[g*POS_W +: POS_W]),
      .moved_o (moved[g]),
      .qerr_o  (qerr[g])
    );
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: idle frames, quadrature counting, chatter,
// illegal transitions, button table, clamping, saturation and reset abort.
module tb_paddle_ctrl;

  localparam int NP    = 2;
  localparam int POS_W = 10;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NP-1:0]      in_a, in_b, mode;
  logic               vsync;
  logic [NP*POS_W-1:0] pos;
  logic [NP-1:0]      moved, qerr;

  int tests = 0;
  int fails = 0;

  int mon_moved [NP];
  int mon_qerr  [NP];
  int qerr_long = 0;

  typedef struct {
    logic a;
    logic b;
    int   exp_pos;
    int   exp_moved;
  } btn_vec_t;

  btn_vec_t          vecs [5];
  logic [POS_W-1:0]  exp_q [$];
  logic [1:0]        gray [4];
  int                gidx;

  paddle_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in_a (in_a),
    .in_b (in_b),
    .mode (mode),
    .vsync(vsync),
    .pos  (pos),
    .moved(moved),
    .qerr (qerr)
  );

  always #5 clk = ~clk;

  function automatic int pos_ch(input int ch);
    return int'(pos[ch*POS_W +: POS_W]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vsync = 1'b0;
    tick(6);
    vsync = 1'b1;
    tick(6);
  endtask

  task automatic quad_fwd(input int steps, input int hold);
    for (int s = 0; s < steps; s++) begin
      gidx = (gidx + 1) % 4;
      in_a[0] = gray[gidx][1];
      in_b[0] = gray[gidx][0];
      tick(hold);
    end
  endtask

  // Moved must coincide exactly with a change of pos outside reset.
  logic [NP*POS_W-1:0] pos_prev;
  logic [NP-1:0]       qerr_prev;
  logic                rst_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NP; i++) begin
        mon_moved[i] += int'(moved[i]);
        mon_qerr[i]  += int'(qerr[i]);
        if (qerr[i] && qerr_prev[i]) qerr_long++;
        if (rst_prev) begin
          tests++;
          if (moved[i] != (pos[i*POS_W +: POS_W] != pos_prev[i*POS_W +: POS_W])) begin
            fails++;
            $display("FAIL moved_vs_pos ch%0d: moved=%0b pos=%0d prev=%0d", i, moved[i],
                     pos[i*POS_W +: POS_W], pos_prev[i*POS_W +: POS_W]);
          end
        end
      end
    end
    pos_prev  = pos;
    qerr_prev = qerr;
    rst_prev  = rst_n;
  end

  initial begin
    int m0, m1, q0, exp_p;
    logic [POS_W-1:0] e;

    gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
    gidx = 0;
    for (int i = 0; i < NP; i++) begin
      mon_moved[i] = 0;
      mon_qerr[i]  = 0;
    end
    vecs[0] = '{a: 1'b0, b: 1'b1, exp_pos: 212, exp_moved: 1};
    vecs[1] = '{a: 1'b1, b: 1'b1, exp_pos: 212, exp_moved: 0};
    vecs[2] = '{a: 1'b1, b: 1'b0, exp_pos: 208, exp_moved: 1};
    vecs[3] = '{a: 1'b0, b: 1'b0, exp_pos: 208, exp_moved: 0};
    vecs[4] = '{a: 1'b1, b: 1'b0, exp_pos: 204, exp_moved: 1};

    rst_n = 1'b0; in_a = '0; in_b = '0; mode = '0; vsync = 1'b1;
    tick(5);
    check("reset_pos0", pos_ch(0), 208);
    check("reset_pos1", pos_ch(1), 208);
    check("reset_moved", int'(moved), 0);
    check("reset_qerr", int'(qerr), 0);
    rst_n = 1'b1;
    tick(5);

    // Idle frames
    repeat (3) frame();
    check("idle_pos0", pos_ch(0), 208);
    check("idle_pos1", pos_ch(1), 208);
    check("idle_moved", mon_moved[0] + mon_moved[1], 0);

    // Five forward quadrature steps on channel 0
    m0 = mon_moved[0];
    quad_fwd(5, 20);
    check("quad_pos0_before_strobe", pos_ch(0), 208);
    frame();
    check("quad_pos0", pos_ch(0), 228);
    check("quad_moved0", mon_moved[0] - m0, 1);
    check("quad_pos1", pos_ch(1), 208);

    // Chatter on A while state is 01
    m0 = mon_moved[0]; q0 = mon_qerr[0];
    for (int t = 0; t < 40; t++) begin
      in_a[0] = ~in_a[0];
      tick(5);
    end
    tick(20);
    frame();
    check("chatter_pos0", pos_ch(0), 228);
    check("chatter_moved0", mon_moved[0] - m0, 0);
    check("chatter_qerr0", mon_qerr[0] - q0, 0);

    // Illegal simultaneous change 01 -> 10
    m0 = mon_moved[0]; q0 = mon_qerr[0];
    in_a[0] = 1'b1; in_b[0] = 1'b0; gidx = 3;
    tick(25);
    check("illegal_qerr0", mon_qerr[0] - q0, 1);
    frame();
    check("illegal_pos0", pos_ch(0), 228);
    check("illegal_moved0", mon_moved[0] - m0, 0);

    // Button mode table on channel 1
    mode[1] = 1'b1;
    tick(2);
    for (int v = 0; v < 5; v++) begin
      in_a[1] = vecs[v].a;
      in_b[1] = vecs[v].b;
      tick(25);
      m1 = mon_moved[1];
      frame();
      check($sformatf("btn_pos1_v%0d", v), pos_ch(1), vecs[v].exp_pos);
      check($sformatf("btn_moved1_v%0d", v), mon_moved[1] - m1, vecs[v].exp_moved);
      check($sformatf("btn_pos0_v%0d", v), pos_ch(0), 228);
    end

    // Hold A for 60 frames: step down and clamp at 0
    m1 = mon_moved[1];
    exp_p = 204;
    for (int f = 0; f < 60; f++) begin
      exp_p = (exp_p >= 4) ? exp_p - 4 : 0;
      exp_q.push_back(POS_W'(exp_p));
      frame();
      e = exp_q.pop_front();
      check($sformatf("clamp_pos1_f%0d", f), pos_ch(1), int'(e));
    end
    check("clamp_moved1", mon_moved[1] - m1, 51);

    // 40 forward steps saturate the accumulator at +31
    m0 = mon_moved[0]; q0 = mon_qerr[0];
    quad_fwd(40, 20);
    check("sat_pos0_before_strobe", pos_ch(0), 228);
    frame();
    check("sat_pos0", pos_ch(0), 228 + 31 * 4);
    check("sat_moved0", mon_moved[0] - m0, 1);
    check("sat_qerr0", mon_qerr[0] - q0, 0);

    // Reset in mid-frame discards pending counts
    quad_fwd(3, 20);
    in_a[1] = 1'b0;
    in_a[0] = 1'b0; in_b[0] = 1'b0; gidx = 0;
    rst_n = 1'b0;
    tick(5);
    check("midrst_pos0", pos_ch(0), 208);
    check("midrst_pos1", pos_ch(1), 208);
    rst_n = 1'b1;
    tick(25);
    m0 = mon_moved[0]; m1 = mon_moved[1]; q0 = mon_qerr[0];
    frame();
    check("postrst_pos0", pos_ch(0), 208);
    check("postrst_pos1", pos_ch(1), 208);
    check("postrst_moved", (mon_moved[0] - m0) + (mon_moved[1] - m1), 0);
    check("postrst_qerr0", mon_qerr[0] - q0, 0);

    // First transition after reset is 00 -> 11
    in_a[0] = 1'b1; in_b[0] = 1'b1;
    tick(25);
    check("first_11_qerr0", mon_qerr[0] - q0, 1);
    frame();
    check("first_11_pos0", pos_ch(0), 208);
    check("first_11_moved0", mon_moved[0] - m0, 0);
    check("qerr_width", qerr_long, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
